// File: rtl/calc1_pkg.sv
// rtl/calc1_pkg.sv - shared command/response codes, widths, FSM states and FIFO entry type for calc1 issuers
package calc1_pkg;

    localparam int CMD_W  = 4;
    localparam int RESP_W = 2;
    localparam int DATA_W = 32;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_LSH = 4'd5;
    localparam logic [CMD_W-1:0] CMD_RSH = 4'd6;

    localparam logic [RESP_W-1:0] RSP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RSP_SUCC = 2'd1;
    localparam logic [RESP_W-1:0] RSP_INOF = 2'd2;
    localparam logic [RESP_W-1:0] RSP_IERR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_OP1,
        ST_SEND_OP2,
        ST_WAIT_RSP,
        ST_HOLD_RES
    } issuer_state_t;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } fifo_entry_t;

endpackage

// File: rtl/calc1_issue_fifo.sv
// rtl/calc1_issue_fifo.sv - DEPTH-entry synchronous FIFO of pending calc1 operations
module calc1_issue_fifo
    import calc1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  fifo_entry_t wdata,
    input  logic        pop,
    output fifo_entry_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_entry_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           wr_en;
    logic           rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign rdata = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/calc1_req_issuer.sv
// rtl/calc1_req_issuer.sv - buffers operations and drives one calc1 request port, one op in flight
// Optional response timeout: CALC1_ISSUER_TIMEOUT_EN
module calc1_req_issuer
    import calc1_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              c_clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic [DATA_W-1:0] req_op1,
    input  logic [DATA_W-1:0] req_op2,
    output logic [CMD_W-1:0]  cmd_out,
    output logic [DATA_W-1:0] data_out,
    input  logic [RESP_W-1:0] resp_in,
    input  logic [DATA_W-1:0] rdata_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RESP_W-1:0] res_resp,
    output logic [DATA_W-1:0] res_data,
    output logic              res_timeout,
    output logic              proto_err
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("calc1_req_issuer: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
    end

    issuer_state_t state;
    fifo_entry_t   op_q;
    fifo_entry_t   push_entry;
    fifo_entry_t   head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    assign req_ready  = ~fifo_full;
    assign push_entry = '{cmd: req_cmd, op1: req_op1, op2: req_op2};
    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;

    calc1_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (c_clk),
        .rst_n (reset_n),
        .push  (req_valid & req_ready),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef CALC1_ISSUER_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
    logic [TO_W-1:0] wait_cnt;
    logic            wait_expired;
    assign wait_expired = (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign res_timeout = 1'b0;
`endif

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            cmd_out   <= CMD_NOP;
            data_out  <= '0;
            res_valid <= 1'b0;
            res_resp  <= RSP_NONE;
            res_data  <= '0;
            proto_err <= 1'b0;
`ifdef CALC1_ISSUER_TIMEOUT_EN
            res_timeout <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            // Any response outside the wait window cannot belong to our op.
            if (resp_in != RSP_NONE && state != ST_WAIT_RSP) proto_err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    cmd_out  <= CMD_NOP;
                    data_out <= '0;
                    if (!fifo_empty) begin
                        op_q <= head;
                        if (head.cmd == CMD_NOP) begin
                            res_resp  <= RSP_NONE;
                            res_data  <= '0;
                            res_valid <= 1'b1;
                            state     <= ST_HOLD_RES;
                        end else begin
                            state <= ST_SEND_OP1;
                        end
                    end
                end
                ST_SEND_OP1: begin
                    cmd_out  <= op_q.cmd;
                    data_out <= op_q.op1;
                    state    <= ST_SEND_OP2;
                end
                ST_SEND_OP2: begin
                    cmd_out  <= CMD_NOP;
                    data_out <= op_q.op2;
                    state    <= ST_WAIT_RSP;
`ifdef CALC1_ISSUER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_WAIT_RSP: begin
                    cmd_out  <= CMD_NOP;
                    data_out <= '0;
                    if (resp_in != RSP_NONE) begin
                        res_resp  <= resp_in;
                        res_data  <= rdata_in;
                        res_valid <= 1'b1;
                        state     <= ST_HOLD_RES;
                    end
`ifdef CALC1_ISSUER_TIMEOUT_EN
                    else if (wait_expired) begin
                        res_resp    <= RSP_NONE;
                        res_data    <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= ST_HOLD_RES;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`endif
                end
                ST_HOLD_RES: begin
                    cmd_out  <= CMD_NOP;
                    data_out <= '0;
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
`ifdef CALC1_ISSUER_TIMEOUT_EN
                        res_timeout <= 1'b0;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_req_issuer.sv
// tb/tb_calc1_req_issuer.sv - randomized scoreboard bench for calc1_req_issuer with a calc1 responder model
module tb_calc1_req_issuer;
    import calc1_pkg::*;

    logic        c_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cmd = '0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic [3:0]  cmd_out;
    logic [31:0] data_out;
    logic [1:0]  resp_in = '0;
    logic [31:0] rdata_in = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [1:0]  res_resp;
    logic [31:0] res_data;
    logic        res_timeout;
    logic        proto_err;

    calc1_req_issuer dut (
        .c_clk(c_clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
        .cmd_out(cmd_out), .data_out(data_out),
        .resp_in(resp_in), .rdata_in(rdata_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_resp(res_resp), .res_data(res_data),
        .res_timeout(res_timeout), .proto_err(proto_err)
    );

    always #5 c_clk = ~c_clk;

    int tests = 0;
    int fails = 0;

    logic [3:0]  iq_c[$];
    logic [31:0] iq_a[$];
    logic [31:0] iq_b[$];
    logic [34:0] rq[$];

    int   cyc = 0, push_cyc = 0, issue_cyc = 0;
    int   phase = 0, dly = 0, rr_mode = 1;
    logic hold_resp = 0, inject = 0, proto_pend = 0, exp_proto = 0, expect_to = 0;
    logic [3:0]  cur_c, last_cmd = '0;
    logic [31:0] cur_a, cur_b;
    logic [33:0] cur_res;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // calc1 behaviour: {resp, data}
    function automatic logic [33:0] calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        case (c)
            CMD_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                calc = s[32] ? {RSP_INOF, 32'd0} : {RSP_SUCC, s[31:0]};
            end
            CMD_SUB: calc = (b > a) ? {RSP_INOF, 32'd0} : {RSP_SUCC, a - b};
            CMD_LSH: calc = {RSP_SUCC, a << b[4:0]};
            CMD_RSH: calc = {RSP_SUCC, a >> b[4:0]};
            CMD_NOP: calc = {RSP_NONE, 32'd0};
            default: calc = {RSP_INOF, 32'd0};
        endcase
    endfunction

    // Push monitor: expected issue order and expected results in push order.
    always @(posedge c_clk) begin
        cyc++;
        if (reset_n && req_valid && req_ready) begin
            push_cyc = cyc;
            if (req_cmd == CMD_NOP) begin
                rq.push_back(35'd0);
            end else begin
                iq_c.push_back(req_cmd);
                iq_a.push_back(req_op1);
                iq_b.push_back(req_op2);
                rq.push_back(expect_to ? {1'b1, 34'd0} : {1'b0, calc(req_cmd, req_op1, req_op2)});
            end
        end
    end

    always @(posedge c_clk) begin
        #1;
        case (rr_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // calc1 responder and per-cycle compare process.
    always @(negedge c_clk) begin
        logic [34:0] e;
        if (!reset_n) begin
            phase   = 0;
            resp_in = '0;
        end else begin
            if (proto_pend) begin
                exp_proto  = 1'b1;
                proto_pend = 1'b0;
            end
            check("proto_err", proto_err, exp_proto);
            if (res_valid) begin
                check("no_issue_while_holding", cmd_out, 0);
                if (res_ready) begin
                    if (rq.size() == 0) check("res_unexpected", res_valid, 0);
                    else begin
                        e = rq.pop_front();
                        check("res_resp", res_resp, e[33:32]);
                        check("res_data", res_data, e[31:0]);
                        check("res_timeout", res_timeout, e[34]);
                    end
                end
            end
            resp_in = '0;
            case (phase)
                0: if (cmd_out != CMD_NOP) begin
                    if (iq_c.size() == 0) check("issue_unexpected", cmd_out, 0);
                    else begin
                        cur_c = iq_c.pop_front();
                        cur_a = iq_a.pop_front();
                        cur_b = iq_b.pop_front();
                        check("issue_cmd", cmd_out, cur_c);
                        check("issue_op1", data_out, cur_a);
                        issue_cyc = cyc;
                        last_cmd  = cmd_out;
                        if (inject) begin
                            resp_in    = RSP_SUCC;
                            inject     = 1'b0;
                            proto_pend = 1'b1;
                        end
                        phase = 1;
                    end
                end
                1: begin
                    check("op2_cmd", cmd_out, CMD_NOP);
                    check("op2_data", data_out, cur_b);
                    cur_res = calc(cur_c, cur_a, cur_b);
                    dly     = int'($urandom_range(0, 4));
                    phase   = 2;
                end
                default: begin
                    check("wait_cmd", cmd_out, CMD_NOP);
                    check("wait_data", data_out, 0);
                    if (res_valid) phase = 0;
                    else if (!hold_resp) begin
                        if (dly == 0) begin
                            resp_in  = cur_res[33:32];
                            rdata_in = cur_res[31:0];
                            phase    = 0;
                        end else dly--;
                    end
                end
            endcase
        end
    end

    task automatic sync();
        @(posedge c_clk);
        #1;
    endtask

    task automatic push_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        req_valid = 1'b1;
        req_cmd   = c;
        req_op1   = a;
        req_op2   = b;
        @(negedge c_clk);
        while (!req_ready && n < 500) begin
            @(negedge c_clk);
            n++;
        end
        if (!req_ready) check("push_timeout", req_ready, 1);
        @(posedge c_clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_res(input int bound);
        int n = 0;
        @(negedge c_clk);
        while (!res_valid && n < bound) begin
            @(negedge c_clk);
            n++;
        end
        if (!res_valid) check("wait_res_timeout", res_valid, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((rq.size() != 0 || iq_c.size() != 0 || res_valid) && n < bound) begin
            @(negedge c_clk);
            n++;
        end
        if (rq.size() != 0) check("drain_timeout", rq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cmds [6];
        cmds = '{CMD_NOP, CMD_ADD, CMD_SUB, CMD_LSH, CMD_RSH, 4'hC};

        repeat (3) @(posedge c_clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_cmd_out", cmd_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_resp", res_resp, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_timeout", res_timeout, 0);
        check("rst_proto_err", proto_err, 0);
        #1 reset_n = 1'b1;
        sync();

        // ADD 255,1 with latency and literal result
        rr_mode = 0;
        push_op(CMD_ADD, 32'd255, 32'd1);
        wait_res(200);
        check("t1_latency", issue_cyc - push_cyc, 2);
        check("t1_resp", res_resp, 1);
        check("t1_data", res_data, 256);
        rr_mode = 1;
        wait_idle(200);

        // overflow and invalid command passthrough
        rr_mode = 0;
        sync();
        push_op(CMD_ADD, 32'hFFFF_FFFF, 32'd1);
        wait_res(200);
        check("t2_ovf_resp", res_resp, 2);
        rr_mode = 1;
        wait_idle(200);
        rr_mode = 0;
        sync();
        push_op(4'hC, 32'd7, 32'd9);
        wait_res(200);
        check("t2_inv_cmd", last_cmd, 4'hC);
        check("t2_inv_resp", res_resp, 2);
        rr_mode = 1;
        wait_idle(200);

        // back-pressure: one op in flight plus a full FIFO
        rr_mode = 0;
        sync();
        for (int i = 0; i < 5; i++) push_op(CMD_ADD, 32'(i * 10), 32'(i));
        check("t3_full_ready", req_ready, 0);
        rr_mode = 1;
        wait_idle(1000);

        // response injected outside the wait window
        sync();
        inject = 1'b1;
        push_op(CMD_SUB, 32'd100, 32'd40);
        wait_idle(200);
        check("t4_proto_sticky", proto_err, 1);

        // randomized traffic
        rr_mode = 2;
        sync();
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            push_op(cmds[$urandom_range(0, 5)], a, b);
            repeat ($urandom_range(0, 3)) @(posedge c_clk);
            #1;
        end
        wait_idle(5000);
        rr_mode = 1;

`ifdef CALC1_ISSUER_TIMEOUT_EN
        rr_mode   = 0;
        hold_resp = 1'b1;
        sync();
        expect_to = 1'b1;
        push_op(CMD_ADD, 32'd1, 32'd2);
        expect_to = 1'b0;
        wait_res(300);
        check("t5_wait_cycles", cyc - issue_cyc, 65);
        check("t5_timeout_flag", res_timeout, 1);
        check("t5_timeout_resp", res_resp, 0);
        hold_resp = 1'b0;
        rr_mode   = 1;
        wait_idle(200);
`endif

        // reset during WAIT_RSP abandons the op
        rr_mode   = 0;
        hold_resp = 1'b1;
        sync();
        push_op(CMD_SUB, 32'd50, 32'd5);
        repeat (8) @(posedge c_clk);
        #3 reset_n = 1'b0;
        #1;
        check("t6_cmd_out", cmd_out, 0);
        check("t6_res_valid", res_valid, 0);
        check("t6_req_ready", req_ready, 1);
        check("t6_proto_err", proto_err, 0);
        iq_c.delete();
        iq_a.delete();
        iq_b.delete();
        rq.delete();
        exp_proto  = 1'b0;
        proto_pend = 1'b0;
        hold_resp  = 1'b0;
        @(posedge c_clk);
        #2 reset_n = 1'b1;
        sync();
        push_op(CMD_SUB, 32'd10, 32'd3);
        wait_res(200);
        check("t6_sub_resp", res_resp, 1);
        check("t6_sub_data", res_data, 7);
        rr_mode = 1;
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
